cache_ctrl: RTL and testbench



---
 rtl/cache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_ctrl                                                   |
// | Description : Controller for a direct-mapped, 64-line, 64-bit-line unified |
// |               cache array. Serves 16-bit pipeline accesses, with hits at   |
// |               zero wait states. A miss performs an optional dirty          |
// |               write-back (EVICT), then a line fill (FILL), then writes the |
// |               line into the array (INSTALL). The cache is write-back and   |
// |               write-allocate.                                              |
// |                                                                            |
// | Ports       : clk, rst_n (asynchronous, active-low)                        |
// |               cpu_*  pipeline side: addr/re/we/wdata in, rdata/stall out   |
// |               c_*    cache array: addr/wr_data/wdirty/we/re out,           |
// |                      rd_data/tag_out/hit/dirty in                          |
// |               m_*    main memory: addr/wr_data/re/we out, rd_data/rdy in   |
// |               hit_cnt, miss_cnt (CACHE_STATS_EN only) saturating counters  |
// |                                                                            |
// | Options     : `define CACHE_STATS_EN adds the hit/miss counters.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cache_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        stall,
    output logic [13:0] c_addr,
    output logic [63:0] c_wr_data,
    output logic        c_wdirty,
    output logic        c_we,
    output logic        c_re,
    input  logic [63:0] c_rd_data,
    input  logic [7:0]  c_tag_out,
    input  logic        c_hit,
    input  logic        c_dirty,
    output logic [13:0] m_addr,
    output logic [63:0] m_wr_data,
    output logic        m_re,
    output logic        m_we,
    input  logic [63:0] m_rd_data,
    input  logic        m_rdy
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EVICT   = 2'd1;
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_INSTALL = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_victim_tag;
    logic [5:0]  r_victim_index;
    logic [63:0] r_victim_line;
    logic [63:0] r_fill_line;

    logic        w_req;
    logic        w_miss;
    logic [63:0] w_hit_merged;
    logic [63:0] w_fill_merged;

    assign w_req  = cpu_re | cpu_we;
    assign w_miss = (r_state == S_IDLE) && w_req && !c_hit;

    // Word k of a line lives in bits [16k+15:16k]; a write replaces only the
    // word selected by cpu_addr[1:0].
    generate
        for (genvar k = 0; k < 4; k++) begin : g_merge
            assign w_hit_merged[16*k +: 16]  = (cpu_addr[1:0] == 2'(k)) ? cpu_wdata
                                                                       : c_rd_data[16*k +: 16];
            assign w_fill_merged[16*k +: 16] = (cpu_addr[1:0] == 2'(k)) ? cpu_wdata
                                                                       : r_fill_line[16*k +: 16];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_victim_tag   <= '0;
            r_victim_index <= '0;
            r_victim_line  <= '0;
            r_fill_line    <= '0;
        end else begin
            r_state <= w_next_state;
            // Capture the victim on the miss cycle; the array may be
            // rewritten before the write-back completes.
            if (w_miss) begin
                r_victim_tag   <= c_tag_out;
                r_victim_index <= cpu_addr[7:2];
                r_victim_line  <= c_rd_data;
            end
            if ((r_state == S_FILL) && m_rdy) begin
                r_fill_line <= m_rd_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        cpu_rdata    = '0;
        c_addr       = cpu_addr[15:2];
        c_wr_data    = '0;
        c_wdirty     = 1'b0;
        c_we         = 1'b0;
        c_re         = 1'b0;
        m_addr       = '0;
        m_wr_data    = '0;
        m_re         = 1'b0;
        m_we         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    c_re = 1'b1;
                    if (c_hit) begin
                        // A write takes priority over a simultaneous read.
                        if (cpu_we) begin
                            c_we      = 1'b1;
                            c_wr_data = w_hit_merged;
                            c_wdirty  = 1'b1;
                        end else begin
                            cpu_rdata = c_rd_data[{cpu_addr[1:0], 4'b0000} +: 16];
                        end
                    end else begin
                        stall        = 1'b1;
                        w_next_state = c_dirty ? S_EVICT : S_FILL;
                    end
                end
            end
            S_EVICT: begin
                stall     = 1'b1;
                c_addr    = {r_victim_tag, r_victim_index};
                m_we      = 1'b1;
                m_addr    = {r_victim_tag, cpu_addr[7:2]};
                m_wr_data = r_victim_line;
                if (m_rdy) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                stall  = 1'b1;
                m_re   = 1'b1;
                m_addr = cpu_addr[15:2];
                if (m_rdy) begin
                    w_next_state = S_INSTALL;
                end
            end
            S_INSTALL: begin
                // The following IDLE cycle re-reads the array and completes
                // the request as a hit.
                stall        = 1'b1;
                c_we         = 1'b1;
                c_wr_data    = cpu_we ? w_fill_merged : r_fill_line;
                c_wdirty     = cpu_we;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        r_after_install;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_after_install <= 1'b0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
        end else begin
            // The hit that finishes a miss is not a genuine hit.
            r_after_install <= (r_state == S_INSTALL);
            if ((r_state == S_IDLE) && w_req && c_hit && !r_after_install &&
                (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cache_ctrl                                                |
// | Description : Self-checking bench for cache_ctrl. It models the cache      |
// |               array and main memory. It also keeps a flat word-level       |
// |               reference of what every address must read back.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic [13:0] c_addr;
    logic [63:0] c_wr_data;
    logic        c_wdirty;
    logic        c_we;
    logic        c_re;
    logic [63:0] c_rd_data;
    logic [7:0]  c_tag_out;
    logic        c_hit;
    logic        c_dirty;
    logic [13:0] m_addr;
    logic [63:0] m_wr_data;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_rd_data;
    logic        m_rdy;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
        .c_addr(c_addr), .c_wr_data(c_wr_data), .c_wdirty(c_wdirty),
        .c_we(c_we), .c_re(c_re), .c_rd_data(c_rd_data),
        .c_tag_out(c_tag_out), .c_hit(c_hit), .c_dirty(c_dirty),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .m_re(m_re), .m_we(m_we),
        .m_rd_data(m_rd_data), .m_rdy(m_rdy)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // ---------------- cache array model ----------------
    logic [7:0]  arr_tag  [0:63];
    logic [63:0] arr_data [0:63];
    logic [63:0] arr_valid;
    logic [63:0] arr_dirty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_valid <= '0;
            arr_dirty <= '0;
        end else if (c_we) begin
            arr_tag[c_addr[5:0]]   <= c_addr[13:6];
            arr_data[c_addr[5:0]]  <= c_wr_data;
            arr_valid[c_addr[5:0]] <= 1'b1;
            arr_dirty[c_addr[5:0]] <= c_wdirty;
        end
    end

    assign c_tag_out = arr_tag[c_addr[5:0]];
    assign c_rd_data = arr_data[c_addr[5:0]];
    assign c_hit     = c_re && arr_valid[c_addr[5:0]] && (arr_tag[c_addr[5:0]] == c_addr[13:6]);
    assign c_dirty   = arr_valid[c_addr[5:0]] && arr_dirty[c_addr[5:0]];

    // ---------------- main memory model ----------------
    logic [63:0]    mem [0:16383];
    logic [16383:0] mem_wr = '0;
    int             mem_delay;
    int             hold_cnt;

    function automatic logic [63:0] init_line(input logic [13:0] a);
        case (a)
            14'h0010: return 64'h4444_3333_2222_1111;
            14'h1010: return 64'h8888_7777_6666_5555;
            default:  return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] mem_line(input logic [13:0] a);
        return mem_wr[a] ? mem[a] : init_line(a);
    endfunction

    assign m_rd_data = mem_line(m_addr);
    assign m_rdy     = (m_re | m_we) && (hold_cnt == mem_delay);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 0;
        end else begin
            if (m_re | m_we) hold_cnt <= m_rdy ? 0 : hold_cnt + 1;
            else             hold_cnt <= 0;
            if (m_we && m_rdy) begin
                mem[m_addr]    <= m_wr_data;
                mem_wr[m_addr] <= 1'b1;
            end
        end
    end

    // ---------------- reference: what each word must read back ----------------
    logic [15:0]    ref_w [0:65535];
    logic [65535:0] ref_set = '0;

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        logic [63:0] l;
        if (ref_set[a]) return ref_w[a];
        l = mem_line(a[15:2]);
        return l[{a[1:0], 4'b0000} +: 16];
    endfunction

    function automatic logic [63:0] ref_line(input logic [13:0] la);
        logic [63:0] l;
        for (int k = 0; k < 4; k++) l[16*k +: 16] = ref_word({la, 2'(k)});
        return l;
    endfunction

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the reference.
    task automatic monitor();
        logic [63:0] exp_l;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                // The array loses its contents; memory becomes the truth.
                ref_set = '0;
                continue;
            end
            chk("mem_excl", {63'b0, m_re & m_we}, 64'd0);
            if ((cpu_re | cpu_we) && !stall) begin
                chk("hit_no_mem", {62'b0, m_re, m_we}, 64'd0);
                if (cpu_we) begin
                    exp_l = ref_line(cpu_addr[15:2]);
                    exp_l[{cpu_addr[1:0], 4'b0000} +: 16] = cpu_wdata;
                    chk("wr_hit_line", c_wr_data, exp_l);
                    chk("wr_hit_we_dirty", {62'b0, c_we, c_wdirty}, 64'd3);
                    ref_w[cpu_addr]   = cpu_wdata;
                    ref_set[cpu_addr] = 1'b1;
                end else begin
                    chk("rd_data", {48'b0, cpu_rdata}, {48'b0, ref_word(cpu_addr)});
                end
            end
            if (!(cpu_re | cpu_we))
                chk("idle_enables", {60'b0, c_we, c_re, m_re, m_we}, 64'd0);
            if (c_we && stall) begin
                exp_l = ref_line(cpu_addr[15:2]);
                if (cpu_we) exp_l[{cpu_addr[1:0], 4'b0000} +: 16] = cpu_wdata;
                chk("install_line", c_wr_data, exp_l);
                chk("install_dirty", {63'b0, c_wdirty}, {63'b0, cpu_we});
            end
            if (m_we && m_rdy)
                chk("wb_line", m_wr_data, ref_line(m_addr));
        end
    endtask

    // ---------------- directed access ----------------
    int          cyc;
    int          cwe_cnt;
    logic        saw_fill, saw_ev, inst_dirty, hitw_dirty;
    logic [13:0] fill_addr, ev_addr;
    logic [63:0] ev_data, inst_data, hitw_data;
    logic [15:0] rdata;

    // Entered just after a rising edge; returns just after the edge that
    // closes the completing cycle, with the request dropped.
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d);
        cpu_addr  = a;
        cpu_we    = w;
        cpu_re    = !w;
        cpu_wdata = d;
        cyc = 0; cwe_cnt = 0; saw_fill = 0; saw_ev = 0;
        fill_addr = '0; ev_addr = '0; ev_data = '0; inst_data = '0; hitw_data = '0;
        inst_dirty = 0; hitw_dirty = 0; rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_re) begin saw_fill = 1; fill_addr = m_addr; end
            if (m_we) begin saw_ev = 1; ev_addr = m_addr; ev_data = m_wr_data; end
            if (c_we) begin
                cwe_cnt++;
                if (stall) begin inst_data = c_wr_data; inst_dirty = c_wdirty; end
                else       begin hitw_data = c_wr_data; hitw_dirty = c_wdirty; end
            end
            if (!stall) begin rdata = cpu_rdata; break; end
            if (cyc >= 40) begin
                checks++;
                failures++;
                $display("FAIL access_timeout addr=%h cycles=%0d required=complete", a, cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_re = 0;
        cpu_we = 0;
    endtask

    initial begin
        rst_n = 0; cpu_addr = '0; cpu_re = 0; cpu_we = 0; cpu_wdata = '0; mem_delay = 0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {58'b0, stall, c_we, c_re, m_re, m_we, c_wdirty}, 64'd0);
        chk("reset_rdata", {48'b0, cpu_rdata}, 64'd0);
        rst_n = 1;

        // Clean read miss, memory answers in the third FILL cycle.
        mem_delay = 2;
        access(16'h0040, 1'b0, 16'h0);
        chk("clean_miss_cycles", 64'(cyc), 64'd6);
        chk("clean_fill_addr", {50'b0, fill_addr}, 64'h0010);
        chk("clean_no_evict", {63'b0, saw_ev}, 64'd0);
        chk("clean_inst_line", inst_data, 64'h4444_3333_2222_1111);
        chk("clean_inst_dirty", {63'b0, inst_dirty}, 64'd0);
        chk("clean_rdata", {48'b0, rdata}, 64'h1111);

        // Read hit.
        mem_delay = 0;
        access(16'h0042, 1'b0, 16'h0);
        chk("rd_hit_cycles", 64'(cyc), 64'd1);
        chk("rd_hit_no_mem", {62'b0, saw_fill, saw_ev}, 64'd0);
        chk("rd_hit_rdata", {48'b0, rdata}, 64'h3333);

        // Write hit.
        access(16'h0041, 1'b1, 16'hBEEF);
        chk("wr_hit_cycles", 64'(cyc), 64'd1);
        chk("wr_hit_cwe_cnt", 64'(cwe_cnt), 64'd1);
        chk("wr_hit_data", hitw_data, 64'h4444_3333_BEEF_1111);
        chk("wr_hit_dirty", {63'b0, hitw_dirty}, 64'd1);

        // Dirty victim at index 0x10.
        mem_delay = 1;
        access(16'h4040, 1'b0, 16'h0);
        chk("dirty_miss_cycles", 64'(cyc), 64'd7);
        chk("evict_seen", {63'b0, saw_ev}, 64'd1);
        chk("evict_addr", {50'b0, ev_addr}, 64'h0010);
        chk("evict_data", ev_data, 64'h4444_3333_BEEF_1111);
        chk("dirty_fill_addr", {50'b0, fill_addr}, 64'h1010);
        chk("dirty_rdata", {48'b0, rdata}, 64'h5555);

        // Write miss with minimum latency.
        mem_delay = 0;
        access(16'h8003, 1'b1, 16'hA5A5);
        chk("wr_miss_cycles", 64'(cyc), 64'd4);
        chk("wr_miss_inst_line", inst_data, 64'hA5A5_0000_0000_0000);
        chk("wr_miss_inst_dirty", {63'b0, inst_dirty}, 64'd1);

        // Evicted data comes back from memory.
        access(16'h0041, 1'b0, 16'h0);
        chk("refetch_cycles", 64'(cyc), 64'd4);
        chk("refetch_no_evict", {63'b0, saw_ev}, 64'd0);
        chk("refetch_rdata", {48'b0, rdata}, 64'hBEEF);
`ifdef CACHE_STATS_EN
        chk("stats_hits", {48'b0, hit_cnt}, 64'd2);
        chk("stats_misses", {48'b0, miss_cnt}, 64'd4);
`endif

        // Reset during FILL.
        mem_delay = 20;
        cpu_addr = 16'h0080;
        cpu_re   = 1;
        repeat (2) @(negedge clk);
        chk("prereset_fill", {62'b0, m_re, stall}, 64'd3);
        #1;
        rst_n  = 0;
        cpu_re = 0;
        #1;
        chk("reset_mid_fill", {62'b0, m_re, stall}, 64'd0);
`ifdef CACHE_STATS_EN
        chk("reset_stats", {32'b0, hit_cnt, miss_cnt}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        mem_delay = 0;
        access(16'h0042, 1'b0, 16'h0);
        chk("post_reset_cycles", 64'(cyc), 64'd4);
        chk("post_reset_rdata", {48'b0, rdata}, 64'h3333);
`ifdef CACHE_STATS_EN
        chk("final_hits", {48'b0, hit_cnt}, 64'd0);
        chk("final_misses", {48'b0, miss_cnt}, 64'd1);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
